// File: rtl/busca_instrucao_pkg.sv
// Shared state encoding and default widths for the instruction-fetch block.
package busca_instrucao_pkg;

   localparam int unsigned LARGURA_END_PADRAO   = 8;
   localparam int unsigned LARGURA_INSTR_PADRAO = 32;
   localparam int unsigned TIMEOUT_PADRAO       = 16;
   localparam int unsigned LARGURA_CONTADOR     = 8;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StReq      = 3'd1,
      StHold     = 3'd2,
      StAtualiza = 3'd3,
      StErro     = 3'd4
   } estado_t;

endpackage

// File: rtl/busca_instrucao_contador_timeout.sv
// Wait-cycle counter for the memory request; flags expiry on the last allowed cycle.
module busca_instrucao_contador_timeout
   import busca_instrucao_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expirou
);

   localparam int unsigned LARGURA = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [LARGURA-1:0] r_cont;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n || i_clear) begin
         r_cont <= '0;
      end else if (i_enable) begin
         r_cont <= r_cont + LARGURA'(1);
      end
   end

   // TIMEOUT of zero disables the watchdog entirely.
   if (TIMEOUT != 0) begin : g_ativo
      assign o_expirou = (r_cont == LARGURA'(TIMEOUT - 1));
   end else begin : g_inativo
      assign o_expirou = 1'b0;
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: samples the PC, reads memory via req/ack, hands the word to the
// decoder via valid/ready and pulses o_escreve_pc so the PC advances.
module busca_instrucao
   import busca_instrucao_pkg::*;
#(
   parameter int unsigned LARGURA_END   = LARGURA_END_PADRAO,
   parameter int unsigned LARGURA_INSTR = LARGURA_INSTR_PADRAO,
   parameter int unsigned TIMEOUT       = TIMEOUT_PADRAO
) (
   input  logic                        i_clock,
   input  logic                        i_reset_n,
   input  logic                        i_habilita,
   input  logic                        i_descarta,
   input  logic [LARGURA_END-1:0]      i_valor_pc,
   output logic                        o_escreve_pc,
   output logic                        o_mem_req,
   output logic [LARGURA_END-1:0]      o_mem_addr,
   input  logic                        i_mem_ack,
   input  logic [LARGURA_INSTR-1:0]    i_mem_data,
   output logic                        o_instr_valid,
   output logic [LARGURA_INSTR-1:0]    o_instr,
   input  logic                        i_instr_ready,
   output logic                        o_erro,
   output logic [LARGURA_CONTADOR-1:0] o_contador_busca
);

   estado_t                     r_estado, w_estado;
   logic                        r_mem_req, w_mem_req;
   logic [LARGURA_END-1:0]      r_mem_addr, w_mem_addr;
   logic [LARGURA_INSTR-1:0]    r_instr, w_instr;
   logic                        r_instr_valid, w_instr_valid;
   logic                        r_escreve_pc, w_escreve_pc;
   logic                        r_erro, w_erro;
   logic [LARGURA_CONTADOR-1:0] r_contador, w_contador;
   logic                        r_descarte, w_descarte;
   logic                        w_cnt_clear, w_cnt_enable, w_expirou;

   busca_instrucao_contador_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_contador_timeout (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_clear   (w_cnt_clear),
      .i_enable  (w_cnt_enable),
      .o_expirou (w_expirou)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_estado      <= StIdle;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= '0;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_escreve_pc  <= 1'b0;
         r_erro        <= 1'b0;
         r_contador    <= '0;
         r_descarte    <= 1'b0;
      end else begin
         r_estado      <= w_estado;
         r_mem_req     <= w_mem_req;
         r_mem_addr    <= w_mem_addr;
         r_instr       <= w_instr;
         r_instr_valid <= w_instr_valid;
         r_escreve_pc  <= w_escreve_pc;
         r_erro        <= w_erro;
         r_contador    <= w_contador;
         r_descarte    <= w_descarte;
      end
   end

   always_comb begin
      w_estado      = r_estado;
      w_mem_req     = r_mem_req;
      w_mem_addr    = r_mem_addr;
      w_instr       = r_instr;
      w_instr_valid = r_instr_valid;
      w_escreve_pc  = 1'b0;
      w_erro        = r_erro;
      w_contador    = r_contador;
      w_descarte    = r_descarte;
      w_cnt_clear   = 1'b0;
      w_cnt_enable  = 1'b0;
      unique case (r_estado)
         StIdle: begin
            if (i_habilita) begin
               w_mem_addr  = i_valor_pc;
               w_mem_req   = 1'b1;
               w_cnt_clear = 1'b1;
               w_estado    = StReq;
            end
         end
         StReq: begin
            if (i_mem_ack) begin
               w_mem_req  = 1'b0;
               w_descarte = 1'b0;
               // A flushed fetch still completes the bus transfer, then drops the word.
               if (r_descarte || i_descarta) begin
                  w_estado = StIdle;
               end else begin
                  w_instr       = i_mem_data;
                  w_instr_valid = 1'b1;
                  w_estado      = StHold;
               end
            end else begin
               if (i_descarta) w_descarte = 1'b1;
               if (w_expirou) begin
                  w_erro     = 1'b1;
                  w_mem_req  = 1'b0;
                  w_descarte = 1'b0;
                  w_estado   = StErro;
               end else begin
                  w_cnt_enable = 1'b1;
               end
            end
         end
         StHold: begin
            if (i_descarta) begin
               w_instr_valid = 1'b0;
               w_estado      = StIdle;
            end else if (i_instr_ready) begin
               w_instr_valid = 1'b0;
               w_escreve_pc  = 1'b1;
               w_contador    = r_contador + LARGURA_CONTADOR'(1);
               w_estado      = StAtualiza;
            end
         end
         StAtualiza: w_estado = StIdle;
         StErro:     w_estado = StErro;
         default:    w_estado = StIdle;
      endcase
   end

   assign o_escreve_pc     = r_escreve_pc;
   assign o_mem_req        = r_mem_req;
   assign o_mem_addr       = r_mem_addr;
   assign o_instr_valid    = r_instr_valid;
   assign o_instr          = r_instr;
   assign o_erro           = r_erro;
   assign o_contador_busca = r_contador;

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: randomized memory/decoder responders with
// expectations derived arithmetically from handshake delays.
module tb_busca_instrucao;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        habilita = 1'b0, descarta = 1'b0;
   logic [7:0]  valor_pc = '0;
   logic        escreve_pc, mem_req, instr_valid, erro;
   logic [7:0]  mem_addr, contador;
   logic        mem_ack = 1'b0, instr_ready = 1'b0;
   logic [31:0] mem_data = '0, instr;

   int checks = 0;
   int errors = 0;
   int model_count = 0;
   int obs_req, obs_req_first, obs_valid, obs_pulses, obs_pulse_t, obs_addr_bad, obs_instr_bad;

   always #5 clk = ~clk;

   busca_instrucao #(
      .LARGURA_END   (8),
      .LARGURA_INSTR (32),
      .TIMEOUT       (16)
   ) dut (
      .i_clock          (clk),
      .i_reset_n        (reset_n),
      .i_habilita       (habilita),
      .i_descarta       (descarta),
      .i_valor_pc       (valor_pc),
      .o_escreve_pc     (escreve_pc),
      .o_mem_req        (mem_req),
      .o_mem_addr       (mem_addr),
      .i_mem_ack        (mem_ack),
      .i_mem_data       (mem_data),
      .o_instr_valid    (instr_valid),
      .o_instr          (instr),
      .i_instr_ready    (instr_ready),
      .o_erro           (erro),
      .o_contador_busca (contador)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; habilita = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; descarta = 1'b0;
      step(); step();
      reset_n = 1'b1; habilita = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
      model_count = 0;
   endtask

   // One fetch from IDLE. The memory acks on its (ack_d+1)-th request cycle, the decoder
   // accepts on its (rdy_d+1)-th valid cycle; optional flush in REQ or together with ready.
   task automatic do_fetch(input logic [7:0] pc, input logic [31:0] data, input int ack_d,
                           input int rdy_d, input int desc_at, input bit desc_hold);
      int r, h, total;
      r = 0; h = 0; total = ack_d + rdy_d + 8;
      obs_req = 0; obs_req_first = -1; obs_valid = 0; obs_pulses = 0; obs_pulse_t = -1;
      obs_addr_bad = 0; obs_instr_bad = 0;
      valor_pc = pc; habilita = 1'b1; descarta = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
      step();
      habilita = 1'b0;
      for (int t = 1; t <= total; t++) begin
         if (mem_req) begin
            obs_req++;
            if (obs_req_first < 0) obs_req_first = t;
            if (mem_addr !== pc) obs_addr_bad++;
         end
         if (instr_valid) begin
            obs_valid++;
            if (instr !== data) obs_instr_bad++;
         end
         if (escreve_pc) begin
            obs_pulses++;
            obs_pulse_t = t;
         end
         valor_pc = 8'($urandom);
         descarta = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
         if (mem_req) begin
            mem_ack  = (r == ack_d);
            mem_data = (r == ack_d) ? data : $urandom;
            descarta = (r == desc_at);
            r++;
         end else if (instr_valid) begin
            instr_ready = (h == rdy_d);
            descarta    = desc_hold && (h == rdy_d);
            h++;
         end else begin
            mem_ack = 1'($urandom); instr_ready = 1'($urandom);
            descarta = 1'($urandom); mem_data = $urandom;
         end
         step();
      end
      mem_ack = 1'b0; instr_ready = 1'b0; descarta = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      reset_n = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1; habilita = 1'b1;
      step(); step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h exp 00", mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
      checks++; if (escreve_pc !== 1'b0) begin errors++; $display("FAIL reset_escreve: got %b exp 0", escreve_pc); end
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b exp 0", erro); end
      checks++; if (contador !== 8'h00) begin errors++; $display("FAIL reset_contador: got %0d exp 0", contador); end
      reset_n = 1'b1; habilita = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b exp 0", mem_req); end
      model_count = 0;
   endtask

   task automatic test_basic();
      do_fetch(8'h05, 32'hDEADBEEF, 0, 0, -1, 1'b0);
      model_count = (model_count + 1) % 256;
      checks++; if (obs_req_first != 1) begin errors++; $display("FAIL basic_req_first: got %0d exp 1", obs_req_first); end
      checks++; if (obs_req != 1) begin errors++; $display("FAIL basic_req_cycles: got %0d exp 1", obs_req); end
      checks++; if (obs_addr_bad != 0) begin errors++; $display("FAIL basic_addr: got %0d bad exp 0", obs_addr_bad); end
      checks++; if (obs_valid != 1) begin errors++; $display("FAIL basic_valid: got %0d exp 1", obs_valid); end
      checks++; if (obs_instr_bad != 0) begin errors++; $display("FAIL basic_instr: got %0d bad exp 0", obs_instr_bad); end
      checks++; if (obs_pulses != 1) begin errors++; $display("FAIL basic_pulses: got %0d exp 1", obs_pulses); end
      checks++; if (obs_pulse_t != 3) begin errors++; $display("FAIL basic_pulse_time: got %0d exp 3", obs_pulse_t); end
      checks++; if (contador !== 8'(model_count)) begin errors++; $display("FAIL basic_contador: got %0d exp %0d", contador, model_count); end
   endtask

   task automatic test_delays();
      do_fetch(8'($urandom), $urandom, 5, 3, -1, 1'b0);
      model_count = (model_count + 1) % 256;
      checks++; if (obs_req != 6) begin errors++; $display("FAIL delay_req: got %0d exp 6", obs_req); end
      checks++; if (obs_addr_bad != 0) begin errors++; $display("FAIL delay_addr: got %0d bad exp 0", obs_addr_bad); end
      checks++; if (obs_valid != 4) begin errors++; $display("FAIL delay_valid: got %0d exp 4", obs_valid); end
      checks++; if (obs_pulses != 1) begin errors++; $display("FAIL delay_pulses: got %0d exp 1", obs_pulses); end
      checks++; if (obs_pulse_t != 11) begin errors++; $display("FAIL delay_pulse_time: got %0d exp 11", obs_pulse_t); end
   endtask

   task automatic test_descarte_req();
      do_fetch(8'h10, $urandom, 4, 0, 2, 1'b0);
      checks++; if (obs_req != 5) begin errors++; $display("FAIL flush_req_hold: got %0d exp 5", obs_req); end
      checks++; if (obs_valid != 0) begin errors++; $display("FAIL flush_req_valid: got %0d exp 0", obs_valid); end
      checks++; if (obs_pulses != 0) begin errors++; $display("FAIL flush_req_pulses: got %0d exp 0", obs_pulses); end
      do_fetch(8'h11, $urandom, 3, 0, 3, 1'b0);
      checks++; if (obs_valid != 0) begin errors++; $display("FAIL flush_with_ack_valid: got %0d exp 0", obs_valid); end
      checks++; if (contador !== 8'(model_count)) begin errors++; $display("FAIL flush_req_contador: got %0d exp %0d", contador, model_count); end
      do_fetch(8'h20, 32'hCAFEF00D, 0, 0, -1, 1'b0);
      model_count = (model_count + 1) % 256;
      checks++; if (obs_addr_bad != 0 || obs_req != 1) begin errors++; $display("FAIL flush_next_addr: got %0d bad %0d req exp 0 1", obs_addr_bad, obs_req); end
      checks++; if (obs_pulses != 1) begin errors++; $display("FAIL flush_next_pulses: got %0d exp 1", obs_pulses); end
   endtask

   task automatic test_descarte_hold();
      do_fetch(8'($urandom), $urandom, 1, 2, -1, 1'b1);
      checks++; if (obs_valid != 3) begin errors++; $display("FAIL flush_hold_valid: got %0d exp 3", obs_valid); end
      checks++; if (obs_pulses != 0) begin errors++; $display("FAIL flush_hold_pulses: got %0d exp 0", obs_pulses); end
      checks++; if (contador !== 8'(model_count)) begin errors++; $display("FAIL flush_hold_contador: got %0d exp %0d", contador, model_count); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         int a, d, mode, at;
         a = $urandom_range(0, 10); d = $urandom_range(0, 5); mode = $urandom_range(0, 2);
         at = (mode == 1) ? $urandom_range(0, a) : -1;
         do_fetch(8'($urandom), $urandom, a, d, at, mode == 2);
         if (mode == 0) model_count = (model_count + 1) % 256;
         checks++; if (obs_req != a + 1 || obs_addr_bad != 0) begin errors++; $display("FAIL rand_req[%0d]: got %0d req %0d bad exp %0d 0", i, obs_req, obs_addr_bad, a + 1); end
         checks++; if (obs_valid != ((mode == 1) ? 0 : d + 1) || obs_instr_bad != 0) begin errors++; $display("FAIL rand_valid[%0d]: got %0d bad %0d mode %0d", i, obs_valid, obs_instr_bad, mode); end
         checks++; if (obs_pulses != ((mode == 0) ? 1 : 0)) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d mode %0d", i, obs_pulses, mode); end
         if (mode == 0) begin
            checks++; if (obs_pulse_t != a + d + 3) begin errors++; $display("FAIL rand_pulse_time[%0d]: got %0d exp %0d", i, obs_pulse_t, a + d + 3); end
         end
         checks++; if (contador !== 8'(model_count)) begin errors++; $display("FAIL rand_contador[%0d]: got %0d exp %0d", i, contador, model_count); end
      end
   endtask

   task automatic test_reset_mid();
      valor_pc = 8'h33; habilita = 1'b1; step();
      habilita = 1'b0; descarta = 1'b1; step();
      descarta = 1'b0;
      reset_n = 1'b0; mem_ack = 1'b1; step();
      checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL reset_mid: got req %b valid %b exp 0 0", mem_req, instr_valid); end
      reset_n = 1'b1; mem_ack = 1'b0; model_count = 0;
      step();
      do_fetch(8'h44, 32'h12345678, 2, 1, -1, 1'b0);
      model_count = 1;
      checks++; if (obs_pulses != 1 || obs_valid != 2) begin errors++; $display("FAIL reset_mid_flag: got pulses %0d valid %0d exp 1 2", obs_pulses, obs_valid); end
   endtask

   task automatic test_timeout();
      int n, bad;
      bit seen;
      n = 0; bad = 0; seen = 1'b0;
      valor_pc = 8'h77; habilita = 1'b1; step();
      habilita = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         if (erro) seen = 1'b1;
         else begin
            if (mem_req) n++;
            step();
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL timeout_erro: got 0 exp 1 within 40 cycles"); end
      checks++; if (n != 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d exp 16", n); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req_drop: got %b exp 0", mem_req); end
      habilita = 1'b1;
      for (int t = 0; t < 10; t++) begin
         mem_ack = 1'($urandom); instr_ready = 1'($urandom);
         step();
         if (mem_req !== 1'b0 || erro !== 1'b1 || instr_valid !== 1'b0 || escreve_pc !== 1'b0) bad++;
      end
      habilita = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL timeout_sticky: got %0d bad cycles exp 0", bad); end
      reset_n = 1'b0; step();
      reset_n = 1'b1; step();
      model_count = 0;
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL timeout_reset: got %b exp 0", erro); end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         do_fetch(8'($urandom), $urandom, $urandom_range(0, 1), $urandom_range(0, 1), -1, 1'b0);
         model_count = (model_count + 1) % 256;
         if (i == 254) begin
            checks++; if (contador !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d exp 255", contador); end
         end
      end
      checks++; if (contador !== 8'(model_count)) begin errors++; $display("FAIL wrap_zero: got %0d exp %0d", contador, model_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delays();
      test_descarte_req();
      test_descarte_hold();
      test_random();
      test_reset_mid();
      test_timeout();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
